// File: rtl/arith_unit_pkg.sv
// Shared constants and types for the arithmetic datapath.
// Bit 1 is the MSB and bit W the LSB; phys() maps that onto [W-1:0] storage.
package arith_unit_pkg;

   localparam int W       = 30;
   localparam int MSB_IDX = 1;
   localparam int LSB_IDX = W;

   typedef logic [W-1:0] mag_t;
   typedef logic [W:0]   bext_t;

   function automatic int phys(input int k);
      return W - k;
   endfunction

endpackage

// File: rtl/arith_unit_adder.sv
// W-bit magnitude adder; the top bit of sum is the carry out.
// Shared by the sum micro-op and the carry status output.
module arith_unit_adder
   import arith_unit_pkg::*;
(
   input  mag_t  a,
   input  mag_t  b,
   output bext_t sum
);

   assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/arith_unit.sv
// A/B/C magnitude registers driven by single-cycle micro-op pulses.
// B[0] (stored as b_q[W]) is the overflow bit above B[1:W].
module arith_unit
   import arith_unit_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  do_clear_a_from_ac,
   input  logic  do_clear_b_from_ac,
   input  logic  do_clear_c_from_ac,
   input  logic  do_not_a_from_ac,
   input  logic  do_not_b_from_ac,
   input  logic  do_sum_from_ac,
   input  logic  do_and_from_ac,
   input  logic  do_set_c_30_from_ac,
   input  logic  do_left_shift_b_from_ac,
   input  logic  do_left_shift_c_from_ac,
   input  logic  do_left_shift_c29_from_ac,
   input  logic  do_right_shift_bc_from_ac,
   input  logic  do_move_c_to_a_from_ac,
   input  logic  do_move_c_to_b_from_ac,
   input  logic  do_move_b_to_c_from_ac,
   input  logic  do_mem_to_c_from_ac,
   input  mag_t  read_data_from_mem,
   input  logic  do_arr_c_from_pnl,
   input  mag_t  arr_reg_c_from_pnl,
   input  logic  io_bit_from_io,
   output logic  carry_out_to_ac,
   output logic  reg_c1_to_ac,
   output logic  reg_c30_to_ac,
   output logic  reg_b0_to_ac,
   output mag_t  write_data_to_mem,
   output mag_t  reg_a_to_pnl,
   output bext_t reg_b_to_pnl,
   output mag_t  reg_c_to_pnl,
   output logic  conflict_to_pnl
);

   localparam int C_MSB = phys(MSB_IDX);
   localparam int C_LSB = phys(LSB_IDX);

   mag_t  a_q, a_d;
   bext_t b_q, b_d;
   mag_t  c_q, c_d;
   logic  conflict_q, conflict_d;

   bext_t           sum;
   bext_t           b_shl;
   mag_t            c_shl;
   logic            c_fill;
   logic [2*W:0]    bc_shr;
   logic [2:0]      a_hits;
   logic [5:0]      b_hits;
   logic [6:0]      c_hits;

   arith_unit_adder u_add (
      .a   (a_q),
      .b   (b_q[W-1:0]),
      .sum (sum)
   );

   assign c_fill = do_left_shift_c29_from_ac & io_bit_from_io;
   assign b_shl  = {b_q[W-1:0], c_q[C_MSB]};
   assign c_shl  = {c_q[W-2:0], c_fill};
   assign bc_shr = {b_q, c_q} >> 1;

   always_comb begin
      a_d = a_q;
      if (do_clear_a_from_ac)
         a_d = '0;
      else if (do_move_c_to_a_from_ac)
         a_d = c_q;
      else if (do_not_a_from_ac)
         a_d = ~a_q;
   end

   always_comb begin
      b_d = b_q;
      if (do_clear_b_from_ac)
         b_d = '0;
      else if (do_move_c_to_b_from_ac)
         b_d = {1'b0, c_q};
      else if (do_sum_from_ac)
         b_d = sum;
      else if (do_left_shift_b_from_ac)
         b_d = b_shl;
      else if (do_right_shift_bc_from_ac)
         b_d = bc_shr[2*W:W];
      else if (do_not_b_from_ac)
         b_d = {b_q[W], ~b_q[W-1:0]};
   end

   // Panel arrangement overrides every C pulse, including set_c_30.
   always_comb begin
      c_d = c_q;
      if (do_arr_c_from_pnl)
         c_d = arr_reg_c_from_pnl;
      else if (do_mem_to_c_from_ac)
         c_d = read_data_from_mem;
      else if (do_move_b_to_c_from_ac)
         c_d = b_q[W-1:0];
      else if (do_and_from_ac)
         c_d = a_q & b_q[W-1:0];
      else if (do_left_shift_c_from_ac)
         c_d = c_shl;
      else if (do_right_shift_bc_from_ac)
         c_d = bc_shr[W-1:0];
      else if (do_clear_c_from_ac)
         c_d = '0;
      if (do_set_c_30_from_ac && !do_arr_c_from_pnl)
         c_d[C_LSB] = 1'b1;
   end

   assign a_hits = {do_clear_a_from_ac, do_move_c_to_a_from_ac,
                    do_not_a_from_ac};
   assign b_hits = {do_clear_b_from_ac, do_move_c_to_b_from_ac,
                    do_sum_from_ac, do_left_shift_b_from_ac,
                    do_right_shift_bc_from_ac, do_not_b_from_ac};
   assign c_hits = {do_mem_to_c_from_ac, do_move_b_to_c_from_ac,
                    do_and_from_ac, do_left_shift_c_from_ac,
                    do_right_shift_bc_from_ac, do_clear_c_from_ac,
                    do_set_c_30_from_ac};

   always_comb begin
      conflict_d = conflict_q;
      if ($countones(a_hits) > 1)
         conflict_d = 1'b1;
      if ($countones(b_hits) > 1)
         conflict_d = 1'b1;
      if (!do_arr_c_from_pnl && $countones(c_hits) > 1)
         conflict_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         conflict_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         conflict_q <= conflict_d;
      end
   end

   assign carry_out_to_ac   = sum[W];
   assign reg_c1_to_ac      = c_q[C_MSB];
   assign reg_c30_to_ac     = c_q[C_LSB];
   assign reg_b0_to_ac      = b_q[W];
   assign write_data_to_mem = c_q;
   assign reg_a_to_pnl      = a_q;
   assign reg_b_to_pnl      = b_q;
   assign reg_c_to_pnl      = c_q;
   assign conflict_to_pnl   = conflict_q;

endmodule

// File: tb/tb_arith_unit.sv
// Scoreboard bench for arith_unit: expectations queued at stimulus,
// popped and compared once the DUT has produced the result.
module tb_arith_unit;
   import arith_unit_pkg::*;

   logic  clk = 1'b0;
   logic  reset = 1'b1;
   logic  clr_a, clr_b, clr_c, not_a, not_b, do_sum, do_and, set30;
   logic  shl_b, shl_c, shl_c29, shr_bc, c2a, c2b, b2c, m2c;
   mag_t  rd_data;
   logic  arr_c;
   mag_t  arr_val;
   logic  io_bit;
   logic  carry, c1, c30, b0, conflict;
   mag_t  wdata, ra, rc;
   bext_t rb;

   arith_unit dut (
      .clk                       (clk),
      .reset                     (reset),
      .do_clear_a_from_ac        (clr_a),
      .do_clear_b_from_ac        (clr_b),
      .do_clear_c_from_ac        (clr_c),
      .do_not_a_from_ac          (not_a),
      .do_not_b_from_ac          (not_b),
      .do_sum_from_ac            (do_sum),
      .do_and_from_ac            (do_and),
      .do_set_c_30_from_ac       (set30),
      .do_left_shift_b_from_ac   (shl_b),
      .do_left_shift_c_from_ac   (shl_c),
      .do_left_shift_c29_from_ac (shl_c29),
      .do_right_shift_bc_from_ac (shr_bc),
      .do_move_c_to_a_from_ac    (c2a),
      .do_move_c_to_b_from_ac    (c2b),
      .do_move_b_to_c_from_ac    (b2c),
      .do_mem_to_c_from_ac       (m2c),
      .read_data_from_mem        (rd_data),
      .do_arr_c_from_pnl         (arr_c),
      .arr_reg_c_from_pnl        (arr_val),
      .io_bit_from_io            (io_bit),
      .carry_out_to_ac           (carry),
      .reg_c1_to_ac              (c1),
      .reg_c30_to_ac             (c30),
      .reg_b0_to_ac              (b0),
      .write_data_to_mem         (wdata),
      .reg_a_to_pnl              (ra),
      .reg_b_to_pnl              (rb),
      .reg_c_to_pnl              (rc),
      .conflict_to_pnl           (conflict)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   localparam int S_A = 0, S_B = 1, S_C = 2, S_CF = 3, S_CY = 4;
   localparam int S_C1 = 5, S_C30 = 6, S_B0 = 7, S_WD = 8;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_chk++;
      if (got === want)
         n_pass++;
      else
         $display("FAIL %s: got %0h want %0h", tag, got, want);
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_A:     return {2'b0, ra};
         S_B:     return {1'b0, rb};
         S_C:     return {2'b0, rc};
         S_CF:    return {31'b0, conflict};
         S_CY:    return {31'b0, carry};
         S_C1:    return {31'b0, c1};
         S_C30:   return {31'b0, c30};
         S_B0:    return {31'b0, b0};
         S_WD:    return {2'b0, wdata};
         default: return '1;
      endcase
   endfunction

   task automatic want(input string tag, input int sel,
                       input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.tag, observe(e.sel), e.val);
      end
   endtask

   task automatic idle();
      {clr_a, clr_b, clr_c, not_a, not_b, do_sum, do_and, set30} = '0;
      {shl_b, shl_c, shl_c29, shr_bc, c2a, c2b, b2c, m2c} = '0;
      arr_c  = 1'b0;
      io_bit = 1'b0;
   endtask

   task automatic go();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic load_c(input logic [29:0] v);
      arr_c   = 1'b1;
      arr_val = v;
      go();
   endtask

   task automatic load_a(input logic [29:0] v);
      load_c(v);
      c2a = 1'b1;
      go();
   endtask

   task automatic load_b(input logic [29:0] v);
      load_c(v);
      c2b = 1'b1;
      go();
   endtask

   task automatic want_zero(input string tag);
      want({tag, "_a"}, S_A, 0);
      want({tag, "_b"}, S_B, 0);
      want({tag, "_c"}, S_C, 0);
      want({tag, "_cf"}, S_CF, 0);
      want({tag, "_cy"}, S_CY, 0);
      want({tag, "_c1"}, S_C1, 0);
      want({tag, "_c30"}, S_C30, 0);
      want({tag, "_b0"}, S_B0, 0);
      want({tag, "_wd"}, S_WD, 0);
   endtask

   localparam logic [29:0] MUL_A = 30'd3;
   localparam logic [29:0] MUL_C = 30'd5;

   initial begin
      idle();
      rd_data = '0;
      arr_val = '0;
      repeat (2) @(posedge clk);
      #1;
      want_zero("rst");
      drain();
      reset = 1'b0;

      load_a(30'd5);
      load_b(30'd7);
      want("sum1_cy", S_CY, 0);
      drain();
      do_sum = 1'b1;
      go();
      want("sum1_b", S_B, 12);
      want("sum1_b0", S_B0, 0);
      drain();

      load_a(30'h2000_0000);
      load_b(30'h2000_0000);
      want("sum2_cy_pre", S_CY, 1);
      drain();
      do_sum = 1'b1;
      go();
      want("sum2_b", S_B, 32'h4000_0000);
      want("sum2_b0", S_B0, 1);
      drain();

      load_a(30'd12);
      load_b(30'd10);
      do_and = 1'b1;
      go();
      want("and_c", S_C, 8);
      want("and_wd", S_WD, 8);
      drain();

      not_a = 1'b1;
      not_b = 1'b1;
      go();
      want("not_a", S_A, 32'h3FFF_FFF3);
      want("not_b", S_B, 32'h3FFF_FFF5);
      want("not_cf", S_CF, 0);
      drain();

      do_sum = 1'b1;
      set30  = 1'b1;
      go();
      want("sumset_b", S_B, 32'h7FFF_FFE8);
      want("sumset_c", S_C, 9);
      want("sumset_c30", S_C30, 1);
      want("sumset_cf", S_CF, 0);
      drain();

      load_b(30'd1);
      load_c(30'h3000_0000);
      shl_b   = 1'b1;
      shl_c   = 1'b1;
      shl_c29 = 1'b1;
      io_bit  = 1'b1;
      go();
      want("div_b", S_B, 3);
      want("div_c", S_C, 32'h2000_0001);
      want("div_c1", S_C1, 1);
      want("div_c30", S_C30, 1);
      want("div_cf", S_CF, 0);
      drain();

      load_a(MUL_A);
      load_c(MUL_C);
      clr_b = 1'b1;
      go();
      for (int i = 0; i < W; i++) begin
         if (i < 30 && MUL_C[i]) begin
            do_sum = 1'b1;
            go();
         end
         shr_bc = 1'b1;
         go();
      end
      want("mul_b", S_B, 0);
      want("mul_c", S_C, 15);
      want("mul_cf", S_CF, 0);
      drain();

      arr_c   = 1'b1;
      arr_val = 30'h123;
      m2c     = 1'b1;
      rd_data = 30'h456;
      go();
      want("arr_c", S_C, 32'h123);
      want("arr_cf", S_CF, 0);
      drain();
      m2c = 1'b1;
      go();
      want("mem_c", S_C, 32'h456);
      drain();

      load_c(30'h55);
      c2b   = 1'b1;
      not_b = 1'b1;
      go();
      want("cfl_b", S_B, 32'h55);
      want("cfl_set", S_CF, 1);
      drain();
      go();
      go();
      want("cfl_sticky", S_CF, 1);
      drain();

      load_a('1);
      load_b('1);
      load_c('1);
      want("ones_a", S_A, 32'h3FFF_FFFF);
      want("ones_b", S_B, 32'h3FFF_FFFF);
      want("ones_c", S_C, 32'h3FFF_FFFF);
      drain();
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      want_zero("midrst");
      drain();
      #20;
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
